// File: rtl/mult_arb_pkg.sv
// Shared types for the multiplier arbiter slice.
// Grant ids, FSM states and sticky error bit positions.
package mult_arb_pkg;

  localparam int ARB_NREQ = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } state_e;

  typedef logic [$clog2(ARB_NREQ)-1:0] req_id_t;

  localparam int ERR_LAST   = 0;
  localparam int ERR_ORPHAN = 1;

endpackage

// File: rtl/tag_fifo.sv
// Owner-tag FIFO: one entry per granted packet pair,
// popped when the matching z packet has returned.
module tag_fifo
  import mult_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = req_id_t
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin packet arbiter sharing one multiplier
// between NREQ requesters, with in-order z steering.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N    = 16,
  parameter int QW   = 64,
  parameter int UW   = 1,
  parameter int NREQ = 2,
  parameter int TAGD = 4
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic [NREQ-1:0][QW-1:0]    req_p_tdata,
  input  logic [NREQ-1:0]            req_p_tvalid,
  input  logic [NREQ-1:0]            req_p_tlast,
  output logic [NREQ-1:0]            req_p_tready,
  input  logic [NREQ-1:0][UW-1:0]    req_u_tdata,
  input  logic [NREQ-1:0]            req_u_tvalid,
  input  logic [NREQ-1:0]            req_u_tlast,
  output logic [NREQ-1:0]            req_u_tready,
  output logic [QW-1:0]              m_p_tdata,
  output logic                       m_p_tvalid,
  output logic                       m_p_tlast,
  input  logic                       m_p_tready,
  output logic [UW-1:0]              m_u_tdata,
  output logic                       m_u_tvalid,
  output logic                       m_u_tlast,
  input  logic                       m_u_tready,
  input  logic [QW-1:0]              s_z_tdata,
  input  logic                       s_z_tvalid,
  input  logic                       s_z_tlast,
  output logic                       s_z_tready,
  output logic [QW-1:0]              req_z_tdata,
  output logic [NREQ-1:0]            req_z_tvalid,
  output logic [NREQ-1:0]            req_z_tlast,
  input  logic [NREQ-1:0]            req_z_tready,
  output logic [$clog2(TAGD):0]      outstanding,
  output logic [1:0]                 err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(N);

  typedef logic [IW-1:0] id_t;

  state_e        state;
  id_t           rr_ptr;
  id_t           gnt;
  id_t           cand;
  id_t           idx;
  id_t           head;
  logic          found;
  logic [CW-1:0] p_cnt;
  logic [CW-1:0] u_cnt;
  logic          p_done;
  logic          u_done;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          feed;
  logic          p_hs;
  logic          u_hs;
  logic          p_end;
  logic          u_end;
  logic          p_last;
  logic          u_last;
  logic          leave;
  int            j;

  // First requester with p valid, scanning up from rr_ptr.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j   = (int'(rr_ptr) + k) % NREQ;
      idx = id_t'(j);
      if (!found && req_p_tvalid[idx] && !full) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  assign feed = state == FEED;
  assign push = (state == IDLE) & found;

  assign p_last     = p_cnt == CW'(N - 1);
  assign m_p_tdata  = req_p_tdata[gnt];
  assign m_p_tvalid = feed & req_p_tvalid[gnt] & ~p_done;
  assign m_p_tlast  = feed & ~p_done & p_last;
  assign p_hs       = m_p_tvalid & m_p_tready;
  assign p_end      = p_hs & p_last;

  assign u_last     = u_cnt == CW'(N - 1);
  assign m_u_tdata  = req_u_tdata[gnt];
  assign m_u_tvalid = feed & req_u_tvalid[gnt] & ~u_done;
  assign m_u_tlast  = feed & ~u_done & u_last;
  assign u_hs       = m_u_tvalid & m_u_tready;
  assign u_end      = u_hs & u_last;

  assign leave = feed & (p_done | p_end)
               & (u_done | u_end);

  always_comb begin
    req_p_tready = '0;
    req_u_tready = '0;
    req_p_tready[gnt] = feed & m_p_tready & ~p_done;
    req_u_tready[gnt] = feed & m_u_tready & ~u_done;
  end

  always_comb begin
    req_z_tvalid = '0;
    req_z_tlast  = '0;
    if (!empty) begin
      req_z_tvalid[head] = s_z_tvalid;
      req_z_tlast[head]  = s_z_tlast;
    end
  end

  assign req_z_tdata = s_z_tdata;
  assign s_z_tready  = ~empty & req_z_tready[head];
  assign pop         = s_z_tvalid & s_z_tready & s_z_tlast;

  tag_fifo #(
    .DEPTH (TAGD),
    .T     (id_t)
  ) u_tags (
    .clk   (clk),
    .arstn (arstn),
    .push  (push),
    .din   (cand),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      p_cnt  <= '0;
      u_cnt  <= '0;
      p_done <= 1'b0;
      u_done <= 1'b0;
      err    <= '0;
    end else begin
      if (s_z_tvalid & empty)
        err[ERR_ORPHAN] <= 1'b1;
      // Count, not the requester's tlast, ends a packet.
      if (p_hs & (req_p_tlast[gnt] != p_last))
        err[ERR_LAST] <= 1'b1;
      if (u_hs & (req_u_tlast[gnt] != u_last))
        err[ERR_LAST] <= 1'b1;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt    <= cand;
            rr_ptr <= (cand == id_t'(NREQ - 1))
                    ? '0 : cand + 1'b1;
            state  <= FEED;
          end
        end
        FEED: begin
          if (leave) begin
            state  <= IDLE;
            p_cnt  <= '0;
            u_cnt  <= '0;
            p_done <= 1'b0;
            u_done <= 1'b0;
          end else begin
            if (p_end)     p_done <= 1'b1;
            else if (p_hs) p_cnt  <= p_cnt + 1'b1;
            if (u_end)     u_done <= 1'b1;
            else if (u_hs) u_cnt  <= u_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin packet arbiter that shares one `multiplier_top` instance between `NREQ` requesters. Each requester offers an N-coefficient p packet and an N-coefficient u packet. The block grants one requester at a time for a whole packet pair and records the owner in a tag FIFO. It then steers the in-order z result packets back to their owners. It sits between the requester-side stream sources and the multiplier's p/u/z AXI-stream ports.

## Interface
Parameters:
- `N`, 16: coefficients per packet.
- `QW`, 64: p and z data width.
- `UW`, 1: u data width.
- `NREQ`, 2: number of requesters (≥2).
- `TAGD`, 4: tag FIFO depth, i.e. maximum outstanding multiplications (power of 2).

Ports (clock and reset first):
- `clk`, in, 1: single clock.
- `arstn`, in, 1: asynchronous active-low reset.
- `req_p_tdata`, in, `NREQ`×`QW`: requester p coefficients.
- `req_p_tvalid` / `req_p_tlast`, in, `NREQ`: per-requester p valid / last.
- `req_p_tready`, out, `NREQ`: per-requester p ready.
- `req_u_tdata`, in, `NREQ`×`UW`; `req_u_tvalid` / `req_u_tlast`, in, `NREQ`; `req_u_tready`, out, `NREQ`: same scheme for u.
- `m_p_tdata`, out, `QW`; `m_p_tvalid` / `m_p_tlast`, out, 1; `m_p_tready`, in, 1: p stream to the multiplier.
- `m_u_tdata`, out, `UW`; `m_u_tvalid` / `m_u_tlast`, out, 1; `m_u_tready`, in, 1: u stream to the multiplier.
- `s_z_tdata`, in, `QW`; `s_z_tvalid` / `s_z_tlast`, in, 1; `s_z_tready`, out, 1: z stream from the multiplier.
- `req_z_tdata`, out, `QW` (broadcast to all requesters); `req_z_tvalid` / `req_z_tlast`, out, `NREQ`; `req_z_tready`, in, `NREQ`: per-requester z return.
- `outstanding`, out, `$clog2(TAGD)+1`: tag FIFO occupancy.
- `err`, out, 2: sticky errors. Bit 0 = tlast misplaced on p or u. Bit 1 = z beat offered while no tag is pending.

## Operation
- Reset values: state IDLE, `rr_ptr` 0, counters 0, tag FIFO empty. All `*_tvalid` and `*_tready` outputs 0, `outstanding` 0, `err` 0.
- State machine has two states, IDLE and FEED.
- **IDLE, grant rule.** A candidate is requester i with `req_p_tvalid[i]`=1 and the tag FIFO not full. The first candidate searching from `rr_ptr` upward (mod `NREQ`) is granted.
  - On grant: `gnt` is registered; `gnt` is pushed into the tag FIFO; `rr_ptr` ← `gnt`+1 mod `NREQ`; state → FEED.
  - With no candidate, stay in IDLE.
- **FEED, p path.** `m_p_tvalid` = `req_p_tvalid[gnt]` & ~`p_done`. `req_p_tready[gnt]` = `m_p_tready` & ~`p_done`. All other requesters' readys are 0. `m_p_tdata` is muxed from `gnt`.
  - `p_cnt` counts handshakes, 0..N-1. `m_p_tlast` is driven by the block as `p_cnt`==N-1; the requester's tlast is not forwarded.
  - The handshake at `p_cnt`==N-1 sets `p_done`.
- **FEED, u path.** Identical to the p path and independent of it, using `u_cnt` and `u_done`.
- **FEED exit.** When both paths are done, state → IDLE and `p_done`/`u_done`/counters are cleared. The two final handshakes may land in the same cycle, or on either path first.
- **tlast check.** A requester tlast that disagrees with `cnt`==N-1 on any accepted beat sets `err[0]`. The packet is still ended by the count.
- **z routing.**
  - `head` is the tag at the FIFO head.
  - `req_z_tvalid[i]` = `s_z_tvalid` & ~empty & (`head`==i); `req_z_tlast[i]` is qualified the same way.
  - `s_z_tready` = ~empty & `req_z_tready[head]`.
  - A z handshake with `s_z_tlast`=1 pops the FIFO.
  - If `s_z_tvalid`=1 while the FIFO is empty: `s_z_tready` stays 0 and `err[1]` is set.
- **FIFO push/pop.** Push in IDLE and pop on a z tlast may occur in the same cycle; occupancy is then unchanged. Push requires the registered not-full condition, so a full-FIFO push never occurs.
- `err` bits clear only on reset.

## Timing
- Grant decision in IDLE at cycle t; first p/u beat can transfer at t+1.
- Final beat of the later path at cycle k → IDLE at k+1 → the next packet's first beat at k+2 at the earliest. The minimum inter-packet gap is therefore 1 cycle.
- The z path is combinational from `req_z_tready`/`s_z_tvalid` to the readys and valids, so z adds zero latency.
- `outstanding` updates the cycle after a push or pop.
- Asynchronous reset mid-packet aborts the packet immediately: all valids and readys drop to 0, and the FIFO and error flags clear.

## Structure
- Package `mult_arb_pkg`: `state_e` {IDLE, FEED}; `req_id_t` (logic [$clog2(NREQ)-1:0]); `ERR_LAST` and `ERR_ORPHAN` bit-index constants.
- Sub-module `tag_fifo`: synchronous FIFO of `req_id_t`, depth `TAGD`, outputs full/empty/count and clears on `arstn`.

## Test plan
- **Single requester.** Requester 0 sends one p and one u packet (N=16) with `m_*_tready`=1. Required: 16 beats on each path, `m_p_tlast` on beat 15, `outstanding`=1. After 16 z beats: `req_z_tvalid[0]` only, and `outstanding` returns to 0.
- **Round-robin.** Both requesters hold valid continuously for 4 packets. Required: grant order 0,1,0,1, and z packets return to owners in the order 0,1,0,1.
- **Skewed paths.** u completes 5 cycles before p. Required: u ready held at 0 after u completes; FEED exits only after p beat 15; the next grant goes to the other requester.
- **FIFO full.** `TAGD`=4, z held idle, 5 packets requested. Required: 4 grants, `outstanding`=4, 5th request stalled. One z packet completes → 5th granted within 2 cycles.
- **Errors.** Requester tlast on beat 7 → `err[0]`=1 and the packet still runs 16 beats. z valid with the FIFO empty → `err[1]`=1 and `s_z_tready`=0.
- **Mid-packet reset.** `arstn` asserted at beat 8. Required: all outputs 0 while in reset. After release, a fresh packet is granted to requester 0.
